spy_path_delay_ctrl: RTL and testbench

//  Sequencer for a spy delay path under test: launches transitions on the path input and times the

---
 rtl/spy_path_delay_ctrl_pkg.sv | 20 ++
 rtl/spy_sync2.sv | 30 +++
 rtl/spy_path_delay_ctrl.sv | 173 +++++++++++++++++
 tb/tb_spy_path_delay_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/spy_path_delay_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spy_pkg
//  Brief    : Shared state encoding and default widths for the spy delay path
//             sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package spy_pkg;

    localparam int c_CNT_W_DEF    = 16;
    localparam int c_TRIALS_W_DEF = 8;
    localparam int c_SETTLE_W_DEF = 8;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETTLE = 2'd1;
    localparam logic [1:0] c_ST_WAIT   = 2'd2;
    localparam logic [1:0] c_ST_FINISH = 2'd3;

endpackage
`default_nettype wire

// File: rtl/spy_sync2.sv
`default_nettype none
// ============================================================================
//  Module   : spy_sync2
//  Brief    : Two-flop synchroniser for the asynchronous path-under-test output.
//  Revision : 1.0  initial release
// ============================================================================
module spy_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/spy_path_delay_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : spy_path_delay_ctrl
//  Brief    : Launches transitions into a delay path under test, times their
//             synchronised arrival and accumulates latency statistics.
//  Revision : 1.0  initial release
// ============================================================================
module spy_path_delay_ctrl
    import spy_pkg::*;
#(
    parameter int CNT_W    = c_CNT_W_DEF,
    parameter int TRIALS_W = c_TRIALS_W_DEF,
    parameter int SETTLE_W = c_SETTLE_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [TRIALS_W-1:0]       num_trials,
    input  logic [CNT_W-1:0]          timeout,
    input  logic [SETTLE_W-1:0]       settle,
    output logic                      path_in,
    input  logic                      path_out,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          min_lat,
    output logic [CNT_W-1:0]          max_lat,
    output logic [CNT_W+TRIALS_W-1:0] sum_lat,
    output logic [TRIALS_W-1:0]       fail_cnt,
    output logic                      pol_flip
);

    localparam int c_SUM_W = CNT_W + TRIALS_W;

    logic [1:0]          r_state;
    logic [TRIALS_W-1:0] r_trials;
    logic [TRIALS_W-1:0] r_trial;
    logic [CNT_W-1:0]    r_timeout;
    logic [SETTLE_W-1:0] r_settle;
    logic [SETTLE_W-1:0] r_scnt;
    logic [CNT_W-1:0]    r_lat;
    logic                r_ref;
    logic                r_path_in;
    logic                r_busy;
    logic                r_done;
    logic [CNT_W-1:0]    r_min;
    logic [CNT_W-1:0]    r_max;
    logic [c_SUM_W-1:0]  r_sum;
    logic [TRIALS_W-1:0] r_fail;
    logic                r_pol_flip;
    logic                r_pol_ref;
    logic                r_pol_ref_vld;
    logic                r_pol_pend;

    logic                w_sync;
    logic                w_settle_end;
    logic                w_arrived;
    logic [TRIALS_W-1:0] w_trial_nxt;
    logic                w_more;
    logic                w_pol;

    spy_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (path_out),
        .q   (w_sync)
    );

    assign w_settle_end = (r_settle == '0) || (r_scnt == r_settle - SETTLE_W'(1));
    assign w_arrived    = (w_sync != r_ref);
    assign w_trial_nxt  = r_trial + TRIALS_W'(1);
    assign w_more       = (w_trial_nxt < r_trials);
    assign w_pol        = w_sync ^ r_path_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_trials      <= '0;
            r_trial       <= '0;
            r_timeout     <= '0;
            r_settle      <= '0;
            r_scnt        <= '0;
            r_lat         <= '0;
            r_ref         <= 1'b0;
            r_path_in     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_min         <= '0;
            r_max         <= '0;
            r_sum         <= '0;
            r_fail        <= '0;
            r_pol_flip    <= 1'b0;
            r_pol_ref     <= 1'b0;
            r_pol_ref_vld <= 1'b0;
            r_pol_pend    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_trials      <= num_trials;
                        r_timeout     <= timeout;
                        r_settle      <= settle;
                        r_trial       <= '0;
                        r_scnt        <= '0;
                        r_min         <= '1;
                        r_max         <= '0;
                        r_sum         <= '0;
                        r_fail        <= '0;
                        r_pol_flip    <= 1'b0;
                        r_pol_ref_vld <= 1'b0;
                        r_pol_pend    <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= (num_trials == '0) ? c_ST_FINISH : c_ST_SETTLE;
                    end
                end
                c_ST_SETTLE: begin
                    if (w_settle_end) begin
                        r_ref     <= w_sync;
                        r_path_in <= ~r_path_in;
                        r_lat     <= CNT_W'(1);
                        r_state   <= c_ST_WAIT;
                        // Polarity of the previous successful trial is judged on the settled level, before launch
                        if (r_pol_pend) begin
                            r_pol_pend <= 1'b0;
                            if (!r_pol_ref_vld) begin
                                r_pol_ref     <= w_pol;
                                r_pol_ref_vld <= 1'b1;
                            end else if (w_pol != r_pol_ref) begin
                                r_pol_flip <= 1'b1;
                            end
                        end
                    end else begin
                        r_scnt <= r_scnt + SETTLE_W'(1);
                    end
                end
                c_ST_WAIT: begin
                    if (w_arrived || (r_lat == r_timeout)) begin
                        if (w_arrived) begin
                            if (r_lat < r_min) r_min <= r_lat;
                            if (r_lat > r_max) r_max <= r_lat;
                            r_sum      <= r_sum + c_SUM_W'(r_lat);
                            r_pol_pend <= 1'b1;
                        end else begin
                            r_fail <= r_fail + TRIALS_W'(1);
                        end
                        r_trial <= w_trial_nxt;
                        r_scnt  <= '0;
                        r_state <= w_more ? c_ST_SETTLE : c_ST_FINISH;
                    end else begin
                        r_lat <= r_lat + CNT_W'(1);
                    end
                end
                c_ST_FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign path_in  = r_path_in;
    assign busy     = r_busy;
    assign done     = r_done;
    assign min_lat  = r_min;
    assign max_lat  = r_max;
    assign sum_lat  = r_sum;
    assign fail_cnt = r_fail;
    assign pol_flip = r_pol_flip;

endmodule
`default_nettype wire

// File: tb/tb_spy_path_delay_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spy_path_delay_ctrl
//  Brief    : Self-checking bench for spy_path_delay_ctrl with a behavioural
//             path model (loopback / clocked delay / stuck-at-0 / inversion).
//  Revision : 1.0  initial release
// ============================================================================
module tb_spy_path_delay_ctrl;

    typedef struct packed {
        int          mode;     // 0 loopback, 1 clocked delay, 2 tied low
        int          dly;
        int          trials;
        int          tmo;
        int          stl;
        logic [15:0] e_min;
        logic [15:0] e_max;
        logic [23:0] e_sum;
        logic [7:0]  e_fail;
        logic        e_pol;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  num_trials;
    logic [15:0] timeout;
    logic [7:0]  settle;
    logic        path_in;
    logic        path_out;
    logic        busy;
    logic        done;
    logic [15:0] min_lat;
    logic [15:0] max_lat;
    logic [23:0] sum_lat;
    logic [7:0]  fail_cnt;
    logic        pol_flip;

    int   total = 0;
    int   bad   = 0;
    int   mode  = 0;
    int   dly   = 1;
    logic ht    = 1'b0;
    logic [7:0] sr;
    int   done_seen = 0;

    spy_path_delay_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_trials (num_trials),
        .timeout    (timeout),
        .settle     (settle),
        .path_in    (path_in),
        .path_out   (path_out),
        .busy       (busy),
        .done       (done),
        .min_lat    (min_lat),
        .max_lat    (max_lat),
        .sum_lat    (sum_lat),
        .fail_cnt   (fail_cnt),
        .pol_flip   (pol_flip)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) sr <= '0;
        else     sr <= {sr[6:0], path_in};
    end

    always_comb begin
        path_out = 1'b0;
        case (mode)
            0:       path_out = path_in ^ ht;
            1:       path_out = sr[dly-1];
            default: path_out = 1'b0;
        endcase
    end

    always @(negedge clk) if (done) done_seen <= done_seen + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected statistics from the path behaviour: every trial sees the same latency.
    function automatic vec_t model(input int md, input int d, input int n, input int tmo, input int stl);
        vec_t v;
        int   lat;
        v.mode = md; v.dly = d; v.trials = n; v.tmo = tmo; v.stl = stl;
        lat = 3 + ((md == 1) ? d : 0);
        if (md != 2 && lat <= tmo && n > 0) begin
            v.e_min = 16'(lat); v.e_max = 16'(lat);
            v.e_sum = 24'(n * lat); v.e_fail = 8'd0;
        end else begin
            v.e_min = 16'hFFFF; v.e_max = 16'd0;
            v.e_sum = 24'd0; v.e_fail = 8'(n);
        end
        v.e_pol = 1'b0;
        return v;
    endfunction

    // poke_kind: 0 none, 1 extra start pulse, 2 assert path inversion
    task automatic run(input int n, input int tmo, input int stl, input int poke_at,
                       input int poke_kind, output bit ok);
        num_trials = 8'(n); timeout = 16'(tmo); settle = 8'(stl);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            start = 1'b0;
            if (c == poke_at && poke_kind == 1) begin
                start = 1'b1;
                num_trials = 8'd7;
            end
            if (c == poke_at && poke_kind == 2) ht = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic run_check(input string nm, input vec_t v, input int poke_at, input int poke_kind);
        bit ok;
        int base;
        mode = v.mode; dly = (v.dly < 1) ? 1 : v.dly;
        repeat (10) @(negedge clk);
        base = done_seen;
        run(v.trials, v.tmo, v.stl, poke_at, poke_kind, ok);
        chk({nm, ".finished"}, 64'(ok), 64'd1);
        chk({nm, ".min"},  64'(min_lat),  64'(v.e_min));
        chk({nm, ".max"},  64'(max_lat),  64'(v.e_max));
        chk({nm, ".sum"},  64'(sum_lat),  64'(v.e_sum));
        chk({nm, ".fail"}, 64'(fail_cnt), 64'(v.e_fail));
        chk({nm, ".pol"},  64'(pol_flip), 64'(v.e_pol));
        chk({nm, ".busy"}, 64'(busy),     64'd0);
        repeat (8) @(negedge clk);
        chk({nm, ".done_pulses"}, 64'(done_seen - base), 64'd1);
    endtask

    vec_t vecs[3];

    initial begin
        vec_t v;
        bit   ok;
        int   base;
        logic lvl;

        vecs[0] = '{mode:0, dly:0, trials:4, tmo:10, stl:4, e_min:16'd3, e_max:16'd3,
                    e_sum:24'd12, e_fail:8'd0, e_pol:1'b0};
        vecs[1] = '{mode:2, dly:0, trials:3, tmo:8, stl:4, e_min:16'hFFFF, e_max:16'd0,
                    e_sum:24'd0, e_fail:8'd3, e_pol:1'b0};
        vecs[2] = '{mode:1, dly:5, trials:2, tmo:20, stl:8, e_min:16'd8, e_max:16'd8,
                    e_sum:24'd16, e_fail:8'd0, e_pol:1'b0};

        rst = 1'b1; start = 1'b0; num_trials = '0; timeout = '0; settle = '0;
        repeat (3) @(negedge clk);
        chk("rst.path_in", 64'(path_in),  64'd0);
        chk("rst.busy",    64'(busy),     64'd0);
        chk("rst.done",    64'(done),     64'd0);
        chk("rst.min",     64'(min_lat),  64'd0);
        chk("rst.max",     64'(max_lat),  64'd0);
        chk("rst.sum",     64'(sum_lat),  64'd0);
        chk("rst.fail",    64'(fail_cnt), 64'd0);
        chk("rst.pol",     64'(pol_flip), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) run_check($sformatf("vec%0d", i), vecs[i], -1, 0);

        // Inversion switched on in the settle gap after trial 2
        v = '{mode:0, dly:0, trials:4, tmo:10, stl:4, e_min:16'd3, e_max:16'd3,
              e_sum:24'd12, e_fail:8'd0, e_pol:1'b1};
        run_check("ht_flip", v, 14, 2);
        ht = 1'b0;

        for (int i = 0; i < 8; i++) begin
            int md, d, n, tmo, stl;
            md  = int'($urandom_range(0, 2));
            d   = (md == 1) ? int'($urandom_range(1, 6)) : 0;
            n   = int'($urandom_range(1, 6));
            tmo = int'($urandom_range(1, 12));
            stl = d + 2 + int'($urandom_range(0, 6));
            run_check($sformatf("rnd%0d", i), model(md, d, n, tmo, stl), -1, 0);
        end

        // Reset while waiting on a stuck path
        mode = 2;
        repeat (10) @(negedge clk);
        num_trials = 8'd2; timeout = 16'd1000; settle = 8'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("rstwait.busy_before", 64'(busy), 64'd1);
        base = done_seen;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstwait.path_in", 64'(path_in), 64'd0);
        chk("rstwait.busy",    64'(busy),    64'd0);
        repeat (20) @(negedge clk);
        chk("rstwait.no_done", 64'(done_seen - base), 64'd0);
        run_check("after_rst", model(0, 0, 2, 10, 3), -1, 0);

        // Zero trials: straight to FINISH, path untouched
        lvl = path_in;
        num_trials = 8'd0; timeout = 16'd10; settle = 8'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("zero.busy",  64'(busy), 64'd1);
        chk("zero.done0", 64'(done), 64'd0);
        @(negedge clk);
        chk("zero.done1",   64'(done),    64'd1);
        chk("zero.path_in", 64'(path_in), 64'(lvl));
        chk("zero.min",     64'(min_lat), 64'hFFFF);
        chk("zero.max",     64'(max_lat), 64'd0);
        @(negedge clk);
        chk("zero.done2",   64'(done),    64'd0);

        // Start pulse during a run must not disturb it
        run_check("busy_start", model(0, 0, 3, 10, 4), 5, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
